// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit spawn controller: state encoding,
// grid geometry defaults, reset fruit position and LFSR seed/taps.
package fruit_pkg;

  localparam int GRID_W_DEF    = 80;
  localparam int GRID_H_DEF    = 60;
  localparam int CELL_PX_DEF   = 10;
  localparam int MAX_TRIES_DEF = 16;

  localparam int CELL_X_W = 7;
  localparam int CELL_Y_W = 6;
  localparam int POS_W    = 11;

  // Centre of cell (39,29): the middle of the playfield.
  localparam logic [POS_W-1:0] RESET_POS_X = 11'd395;
  localparam logic [POS_W-1:0] RESET_POS_Y = 11'd295;

  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_QUERY,
    ST_COMMIT
`ifdef FRUIT_SCAN_FALLBACK_EN
    , ST_SCAN
`endif
  } state_t;

endpackage

// File: rtl/fruit_spawn_ctrl_if.sv
// Occupancy query channel between the spawn controller (master) and the
// snake body store (slave).
interface fruit_spawn_ctrl_if;
  import fruit_pkg::*;

  logic                qry_req;
  logic [CELL_X_W-1:0] qry_cell_x;
  logic [CELL_Y_W-1:0] qry_cell_y;
  logic                qry_ack;
  logic                qry_occupied;

  modport master (
    output qry_req, qry_cell_x, qry_cell_y,
    input  qry_ack, qry_occupied
  );

  modport slave (
    input  qry_req, qry_cell_x, qry_cell_y,
    output qry_ack, qry_occupied
  );
endinterface

// File: rtl/fruit_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running, reseeded on rst.
module fruit_lfsr
  import fruit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/fruit_spawn_ctrl.sv
// Fruit spawn controller: on each eat edge, tries random cells until one is
// free, then places the fruit. FRUIT_SCAN_FALLBACK_EN adds a linear scan fallback.
module fruit_spawn_ctrl
  import fruit_pkg::*;
#(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int CELL_PX   = CELL_PX_DEF,
  parameter int MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               comer,
  fruit_spawn_ctrl_if.master qry,
  output logic [POS_W-1:0]   fruitPositionX,
  output logic [POS_W-1:0]   fruitPositionY,
  output logic               fruit_valid,
  output logic               spawn_busy,
  output logic               spawn_fail
);

  localparam int                TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0]  LAST_TRY = TRY_W'(MAX_TRIES - 1);

  state_t              r_state;
  logic                r_comer_d;
  logic                r_pending;
  logic [TRY_W-1:0]    r_tries;
  logic [CELL_X_W-1:0] r_cell_x;
  logic [CELL_Y_W-1:0] r_cell_y;
  logic [POS_W-1:0]    r_pos_x;
  logic [POS_W-1:0]    r_pos_y;
  logic                r_valid;
  logic                r_busy;
  logic                r_fail;
  logic                r_qry_req;

  logic [15:0]         w_lfsr;
  logic                w_lfsr_unused;
  logic                w_eat;
  logic [CELL_X_W-1:0] w_cand_x;
  logic [CELL_Y_W-1:0] w_cand_y;

  fruit_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .o_lfsr (w_lfsr)
  );

  assign w_lfsr_unused = ^{w_lfsr[15:14], w_lfsr[7]};
  assign w_eat         = comer & ~r_comer_d;

  // One conditional subtract suffices: 127 < 2*80 and 63 < 2*60.
  always_comb begin
    w_cand_x = w_lfsr[6:0];
    w_cand_y = w_lfsr[13:8];
    if (w_cand_x >= CELL_X_W'(GRID_W)) w_cand_x = w_cand_x - CELL_X_W'(GRID_W);
    if (w_cand_y >= CELL_Y_W'(GRID_H)) w_cand_y = w_cand_y - CELL_Y_W'(GRID_H);
  end

`ifdef FRUIT_SCAN_FALLBACK_EN
  localparam int               SCAN_W    = $clog2(GRID_W * GRID_H);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(GRID_W * GRID_H - 1);

  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [CELL_X_W-1:0] w_next_x;
  logic [CELL_Y_W-1:0] w_next_y;

  always_comb begin
    w_next_x = r_cell_x + CELL_X_W'(1);
    w_next_y = r_cell_y;
    if (r_cell_x == CELL_X_W'(GRID_W - 1)) begin
      w_next_x = '0;
      w_next_y = (r_cell_y == CELL_Y_W'(GRID_H - 1)) ? '0 : r_cell_y + CELL_Y_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_comer_d <= 1'b1;
      r_pending <= 1'b0;
      r_tries   <= '0;
      r_cell_x  <= '0;
      r_cell_y  <= '0;
      r_pos_x   <= RESET_POS_X;
      r_pos_y   <= RESET_POS_Y;
      r_valid   <= 1'b1;
      r_busy    <= 1'b0;
      r_fail    <= 1'b0;
      r_qry_req <= 1'b0;
`ifdef FRUIT_SCAN_FALLBACK_EN
      r_scan_cnt <= '0;
`endif
    end else begin
      r_comer_d <= comer;
      case (r_state)
        ST_IDLE: begin
          if (w_eat || r_pending) begin
            r_valid   <= 1'b0;
            r_tries   <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_PICK;
          end
        end
        ST_PICK: begin
          r_cell_x  <= w_cand_x;
          r_cell_y  <= w_cand_y;
          r_qry_req <= 1'b1;
          r_state   <= ST_QUERY;
        end
        ST_QUERY: begin
          if (qry.qry_ack) begin
            if (!qry.qry_occupied) begin
              r_qry_req <= 1'b0;
              r_state   <= ST_COMMIT;
            end else if (r_tries < LAST_TRY) begin
              r_tries   <= r_tries + TRY_W'(1);
              r_qry_req <= 1'b0;
              r_state   <= ST_PICK;
            end else begin
`ifdef FRUIT_SCAN_FALLBACK_EN
              r_cell_x   <= w_next_x;
              r_cell_y   <= w_next_y;
              r_scan_cnt <= '0;
              r_state    <= ST_SCAN;
`else
              r_qry_req <= 1'b0;
              r_fail    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
`endif
            end
          end
        end
`ifdef FRUIT_SCAN_FALLBACK_EN
        ST_SCAN: begin
          if (qry.qry_ack) begin
            if (!qry.qry_occupied) begin
              r_qry_req <= 1'b0;
              r_state   <= ST_COMMIT;
            end else if (r_scan_cnt == SCAN_LAST) begin
              r_qry_req <= 1'b0;
              r_fail    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
              r_cell_x   <= w_next_x;
              r_cell_y   <= w_next_y;
            end
          end
        end
`endif
        ST_COMMIT: begin
          r_pos_x <= POS_W'(int'(r_cell_x) * CELL_PX + CELL_PX / 2);
          r_pos_y <= POS_W'(int'(r_cell_y) * CELL_PX + CELL_PX / 2);
          r_valid <= 1'b1;
          r_fail  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // A single pending slot; extra eats while busy collapse into it.
      if (r_state != ST_IDLE && w_eat) r_pending <= 1'b1;
    end
  end

  assign qry.qry_req    = r_qry_req;
  assign qry.qry_cell_x = r_cell_x;
  assign qry.qry_cell_y = r_cell_y;
  assign fruitPositionX = r_pos_x;
  assign fruitPositionY = r_pos_y;
  assign fruit_valid    = r_valid;
  assign spawn_busy     = r_busy;
  assign spawn_fail     = r_fail;

endmodule

// File: tb/tb_fruit_spawn_ctrl.sv
// Directed self-checking bench for fruit_spawn_ctrl; the scan-fallback step
// follows FRUIT_SCAN_FALLBACK_EN.
module tb_fruit_spawn_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        comer = 1'b0;
  logic [10:0] fx, fy;
  logic        fv, busy, fail;
  logic [15:0] m_lfsr;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [6:0]  ex;
  logic [5:0]  ey;
  logic [10:0] px, py;
  int          extra_busy;

  fruit_spawn_ctrl_if qif ();

  fruit_spawn_ctrl #(
    .GRID_W(80), .GRID_H(60), .CELL_PX(10), .MAX_TRIES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .comer          (comer),
    .qry            (qif.master),
    .fruitPositionX (fx),
    .fruitPositionY (fy),
    .fruit_valid    (fv),
    .spawn_busy     (busy),
    .spawn_fail     (fail)
  );

  always #5 clk = ~clk;

  // Reference LFSR, stepped on the same edges as the design's generator.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] cand_x(input logic [15:0] r);
    logic [6:0] v;
    v = r[6:0];
    if (v >= 7'd80) v = v - 7'd80;
    return v;
  endfunction

  function automatic logic [5:0] cand_y(input logic [15:0] r);
    logic [5:0] v;
    v = r[13:8];
    if (v >= 6'd60) v = v - 6'd60;
    return v;
  endfunction

  function automatic logic [10:0] pix(input int c);
    return 11'(c * 10 + 5);
  endfunction

  task automatic advance_cell(inout logic [6:0] x, inout logic [5:0] y);
    if (x == 7'd79) begin
      x = 7'd0;
      y = (y == 6'd59) ? 6'd0 : y + 6'd1;
    end else begin
      x = x + 7'd1;
    end
  endtask

  initial begin
    qif.qry_ack      = 1'b0;
    qif.qry_occupied = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_pos_x", 32'(fx), 32'(395));
    check("rst_pos_y", 32'(fy), 32'(295));
    check("rst_valid", 32'(fv), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_qry_req", 32'(qif.qry_req), 32'(0));
    check("rst_fail", 32'(fail), 32'(0));
    rst = 1'b0;
    step();

    // Basic spawn, ack already high, cell free: fruit visible four edges later
    qif.qry_ack = 1'b1;
    qif.qry_occupied = 1'b0;
    comer = 1'b1; step(); comer = 1'b0;
    check("b_valid_clr", 32'(fv), 32'(0));
    check("b_busy", 32'(busy), 32'(1));
    ex = cand_x(m_lfsr); ey = cand_y(m_lfsr);
    step();
    check("b_qry_req", 32'(qif.qry_req), 32'(1));
    check("b_cell_x", 32'(qif.qry_cell_x), 32'(ex));
    check("b_cell_y", 32'(qif.qry_cell_y), 32'(ey));
    step();
    check("b_valid_c3", 32'(fv), 32'(0));
    check("b_req_drop", 32'(qif.qry_req), 32'(0));
    step();
    px = pix(int'(ex)); py = pix(int'(ey));
    check("b_valid_c4", 32'(fv), 32'(1));
    check("b_pos_x", 32'(fx), 32'(px));
    check("b_pos_y", 32'(fy), 32'(py));
    check("b_busy_done", 32'(busy), 32'(0));
    check("b_x_range", 32'(fx >= 11'd5 && fx <= 11'd795 && (fx % 11'd10) == 11'd5), 32'(1));
    check("b_y_range", 32'(fy >= 11'd5 && fy <= 11'd595 && (fy % 11'd10) == 11'd5), 32'(1));

    // Ack held off three cycles: request and cell stay put
    qif.qry_ack = 1'b0;
    comer = 1'b1; step(); comer = 1'b0;
    ex = cand_x(m_lfsr); ey = cand_y(m_lfsr);
    step();
    check("h_req_0", 32'(qif.qry_req), 32'(1));
    check("h_cell_x_0", 32'(qif.qry_cell_x), 32'(ex));
    check("h_cell_y_0", 32'(qif.qry_cell_y), 32'(ey));
    for (int i = 0; i < 3; i++) begin
      step();
      check("h_req_wait", 32'(qif.qry_req), 32'(1));
      check("h_cell_x_wait", 32'(qif.qry_cell_x), 32'(ex));
      check("h_cell_y_wait", 32'(qif.qry_cell_y), 32'(ey));
      check("h_valid_wait", 32'(fv), 32'(0));
    end
    qif.qry_ack = 1'b1;
    step();
    check("h_req_drop", 32'(qif.qry_req), 32'(0));
    check("h_busy_commit", 32'(busy), 32'(1));
    step();
    px = pix(int'(ex)); py = pix(int'(ey));
    check("h_valid", 32'(fv), 32'(1));
    check("h_pos_x", 32'(fx), 32'(px));
    check("h_pos_y", 32'(fy), 32'(py));

    // Sixteen occupied random candidates
    qif.qry_occupied = 1'b1;
    comer = 1'b1; step(); comer = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ex = cand_x(m_lfsr); ey = cand_y(m_lfsr);
      step();
      check("t_cell_x", 32'(qif.qry_cell_x), 32'(ex));
      check("t_cell_y", 32'(qif.qry_cell_y), 32'(ey));
      step();
    end
`ifdef FRUIT_SCAN_FALLBACK_EN
    advance_cell(ex, ey);
    check("s_busy", 32'(busy), 32'(1));
    check("s_req", 32'(qif.qry_req), 32'(1));
    check("s_cell_x1", 32'(qif.qry_cell_x), 32'(ex));
    check("s_cell_y1", 32'(qif.qry_cell_y), 32'(ey));
    step();
    advance_cell(ex, ey);
    check("s_cell_x2", 32'(qif.qry_cell_x), 32'(ex));
    check("s_cell_y2", 32'(qif.qry_cell_y), 32'(ey));
    step();
    advance_cell(ex, ey);
    check("s_cell_x3", 32'(qif.qry_cell_x), 32'(ex));
    check("s_cell_y3", 32'(qif.qry_cell_y), 32'(ey));
    qif.qry_occupied = 1'b0;
    step();
    step();
    px = pix(int'(ex)); py = pix(int'(ey));
    check("s_valid", 32'(fv), 32'(1));
    check("s_pos_x", 32'(fx), 32'(px));
    check("s_pos_y", 32'(fy), 32'(py));
    check("s_fail", 32'(fail), 32'(0));
`else
    check("f_fail", 32'(fail), 32'(1));
    check("f_valid", 32'(fv), 32'(0));
    check("f_busy", 32'(busy), 32'(0));
    check("f_req", 32'(qif.qry_req), 32'(0));
    check("f_keep_x", 32'(fx), 32'(px));
    check("f_keep_y", 32'(fy), 32'(py));
    qif.qry_occupied = 1'b0;
    comer = 1'b1; step(); comer = 1'b0;
    check("f_fail_hold", 32'(fail), 32'(1));
    ex = cand_x(m_lfsr); ey = cand_y(m_lfsr);
    repeat (3) step();
    px = pix(int'(ex)); py = pix(int'(ey));
    check("f_retry_fail", 32'(fail), 32'(0));
    check("f_retry_valid", 32'(fv), 32'(1));
    check("f_retry_x", 32'(fx), 32'(px));
    check("f_retry_y", 32'(fy), 32'(py));
`endif

    // Two eats while busy produce exactly one extra spawn
    qif.qry_ack = 1'b0;
    qif.qry_occupied = 1'b0;
    comer = 1'b1; step(); comer = 1'b0;
    step();
    comer = 1'b1; step(); comer = 1'b0;
    step();
    comer = 1'b1; step(); comer = 1'b0;
    qif.qry_ack = 1'b1;
    step();
    step();
    check("p_first_valid", 32'(fv), 32'(1));
    check("p_first_idle", 32'(busy), 32'(0));
    step();
    check("p_second_busy", 32'(busy), 32'(1));
    check("p_second_clr", 32'(fv), 32'(0));
    ex = cand_x(m_lfsr); ey = cand_y(m_lfsr);
    step();
    check("p_cell_x", 32'(qif.qry_cell_x), 32'(ex));
    check("p_cell_y", 32'(qif.qry_cell_y), 32'(ey));
    step();
    step();
    px = pix(int'(ex)); py = pix(int'(ey));
    check("p_second_valid", 32'(fv), 32'(1));
    check("p_second_x", 32'(fx), 32'(px));
    check("p_second_y", 32'(fy), 32'(py));
    extra_busy = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy) extra_busy++;
    end
    check("p_no_third", 32'(extra_busy), 32'(0));

    // Reset in the middle of a query
    qif.qry_ack = 1'b0;
    comer = 1'b1; step(); comer = 1'b0;
    step();
    check("r_req_before", 32'(qif.qry_req), 32'(1));
    step();
    rst = 1'b1;
    step();
    check("r_req_drop", 32'(qif.qry_req), 32'(0));
    check("r_pos_x", 32'(fx), 32'(395));
    check("r_pos_y", 32'(fy), 32'(295));
    check("r_valid", 32'(fv), 32'(1));
    check("r_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    qif.qry_ack = 1'b1;
    step();
    step();
    check("r_late_ack_req", 32'(qif.qry_req), 32'(0));
    check("r_late_ack_busy", 32'(busy), 32'(0));
    check("r_late_ack_valid", 32'(fv), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
